imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 1024: instruction memory capacity in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first word written; word-aligned.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low (rst==0 resets on the next rising edge of clk).
REQ-005 start  input  1  single-cycle request to begin a load session.
REQ-006 in_valid  input  1  byte-stream data valid.
REQ-007 in_data  input  8  byte-stream data.
REQ-008 in_ready  output  1  loader can accept a byte this cycle.
REQ-009 WE  output  1  instruction-memory write enable.
REQ-010 A  output  32  instruction-memory byte address for the write; A[1:0] always 0.
REQ-011 WD  output  32  instruction-memory write data.
REQ-012 busy  output  1  session in progress (any state except IDLE, DONE, ERR).
REQ-013 done  output  1  session completed successfully; held until next start or reset.
REQ-014 err  output  1  session aborted on bad length; held until next start or reset.
REQ-015 words_written  output  16  count of words written in the current/last session.

Function
REQ-016 The loader SHALL implement states IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR.
REQ-017 A byte SHALL be accepted only on a cycle with in_valid==1 and in_ready==1.
REQ-018 in_ready SHALL be 1 exactly in states LEN0, LEN1, DATA, decoded combinationally from state.
REQ-019 IDLE/DONE/ERR: start==1 SHALL move to LEN0 and clear done, err, words_written and the byte index; otherwise hold.
REQ-020 start SHALL be ignored while busy==1.
REQ-021 LEN0: accepted byte SHALL become N[7:0], then go to LEN1.
REQ-022 LEN1: accepted byte SHALL become N[15:8]; then N==0 -> DONE, N>DEPTH -> ERR, else DATA.
REQ-023 DATA: the k-th accepted byte (k=0..3) SHALL be stored in WD[8k+7:8k] (little-endian); after the byte with k==3 the state SHALL become WRITE and the byte index SHALL wrap to 0.
REQ-024 WRITE SHALL last exactly one cycle with WE==1, A==BASE_ADDR+4*words_written, WD==assembled word.
REQ-025 On leaving WRITE words_written SHALL increment by 1; next state DONE if the new count equals N, else DATA.
REQ-026 Latency: WE SHALL assert on the cycle after the 4th byte of a word is accepted.
REQ-027 WE SHALL be 0 in every state other than WRITE; A and WD SHALL hold their last values outside WRITE.
REQ-028 Throughput: one word per 5 cycles when in_valid is held high.
REQ-029 in_valid deasserted mid-word SHALL stall without losing partially assembled bytes.
REQ-030 DONE SHALL drive done==1; ERR SHALL drive err==1; done and err SHALL never both be 1.
REQ-031 Bytes presented while in_ready==0 SHALL be ignored.

Reset
REQ-032 On rst==0 at a clock edge: state=IDLE, WE=0, A=BASE_ADDR, WD=0, done=0, err=0, words_written=0, byte index=0, N=0.
REQ-033 Reset SHALL take priority over start and any byte acceptance, including mid-session; no further WE pulses SHALL occur from the aborted session.

Verification
REQ-034 start; bytes 02 00 13 05 A0 00 93 05 10 00 -> WE pulses at A=0x0 WD=0x00A00513 and A=0x4 WD=0x00100593; done=1, words_written=2.
REQ-035 start; length bytes 00 00 -> DONE two cycles after LEN1 accept, no WE, done=1, words_written=0.
REQ-036 DEPTH=1024, length bytes 01 04 (N=1025) -> err=1, no WE, in_ready=0 afterwards.
REQ-037 N=1, in_valid toggled every other cycle during data -> single WE with correct WD=assembled word, done=1.
REQ-038 rst=0 after 2 of 4 data bytes -> next cycle state IDLE, all outputs at reset values; new start reloads from A=BASE_ADDR.
REQ-039 start pulsed while in DATA -> ignored, session completes normally; start in DONE -> new session, done cleared.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a 16-bit little-endian word count followed by
// little-endian 32-bit words on a byte stream and writes them to consecutive word addresses.
module imem_loader #(
   parameter int          DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        WE,
   output logic [31:0] A,
   output logic [31:0] WD,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] words_written
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_e;

   localparam logic [16:0] DEPTH_L = 17'(DEPTH);

   state_e      state_q, state_d;
   logic [15:0] n_q, n_d;
   logic [1:0]  idx_q, idx_d;
   logic [23:0] asm_q, asm_d;
   logic        we_q, we_d;
   logic [31:0] a_q, a_d;
   logic [31:0] wd_q, wd_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [15:0] words_q, words_d;

   logic        accept;
   logic [15:0] len_n;
   logic [15:0] words_inc;
   logic [31:0] wr_addr;

   assign in_ready  = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA);
   assign busy      = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
   assign accept    = in_valid && in_ready;
   assign len_n     = {in_data, n_q[7:0]};
   assign words_inc = words_q + 16'd1;
   assign wr_addr   = BASE_ADDR + {14'd0, words_q, 2'b00};

   // NOTE: every _d starts from its _q (and WE from 0) so no path leaves a signal unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      idx_d   = idx_q;
      asm_d   = asm_q;
      we_d    = 1'b0;
      a_d     = a_q;
      wd_d    = wd_q;
      done_d  = done_q;
      err_d   = err_q;
      words_d = words_q;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_LEN0;
               done_d  = 1'b0;
               err_d   = 1'b0;
               words_d = 16'd0;
               idx_d   = 2'd0;
            end
         end

         S_LEN0: begin
            if (accept) begin
               n_d[7:0] = in_data;
               state_d  = S_LEN1;
            end
         end

         S_LEN1: begin
            if (accept) begin
               n_d[15:8] = in_data;
               if (len_n == 16'd0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else if ({1'b0, len_n} > DEPTH_L) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_DATA;
               end
            end
         end

         S_DATA: begin
            if (accept) begin
               idx_d = idx_q + 2'd1;
               case (idx_q)
                  2'd0: asm_d[7:0]   = in_data;
                  2'd1: asm_d[15:8]  = in_data;
                  2'd2: asm_d[23:16] = in_data;
                  default: begin
                     // Last byte goes straight into WD so the write issues on the next cycle.
                     state_d = S_WRITE;
                     we_d    = 1'b1;
                     a_d     = wr_addr;
                     wd_d    = {in_data, asm_q};
                  end
               endcase
            end
         end

         S_WRITE: begin
            words_d = words_inc;
            if (words_inc == n_q) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               state_d = S_DATA;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         n_q     <= 16'd0;
         idx_q   <= 2'd0;
         asm_q   <= 24'd0;
         we_q    <= 1'b0;
         a_q     <= BASE_ADDR;
         wd_q    <= 32'd0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         words_q <= 16'd0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         idx_q   <= idx_d;
         asm_q   <= asm_d;
         we_q    <= we_d;
         a_q     <= a_d;
         wd_q    <= wd_d;
         done_q  <= done_d;
         err_q   <= err_d;
         words_q <= words_d;
      end
   end

   assign WE            = we_q;
   assign A             = a_q;
   assign WD            = wd_q;
   assign done          = done_q;
   assign err           = err_q;
   assign words_written = words_q;

   a_done_err_excl : assert property (@(posedge clk) disable iff (!rst) !(done_q && err_q));
   a_we_in_write   : assert property (@(posedge clk) disable iff (!rst) we_q == (state_q == S_WRITE));
   a_addr_aligned  : assert property (@(posedge clk) disable iff (!rst) a_q[1:0] == 2'b00);

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: one task per scenario, WE pulses
// captured by a negedge monitor and compared against hand-computed words/addresses.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        WE;
   logic [31:0] A;
   logic [31:0] WD;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] words_written;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int we_cnt = 0;
   logic [31:0] we_a   [8];
   logic [31:0] we_wd  [8];
   int          we_cyc [8];

   imem_loader #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .WE(WE), .A(A), .WD(WD), .busy(busy), .done(done),
      .err(err), .words_written(words_written)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (WE === 1'b1) begin
         if (we_cnt < 8) begin
            we_a[we_cnt]   = A;
            we_wd[we_cnt]  = WD;
            we_cyc[we_cnt] = cyc;
         end
         we_cnt++;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      tick(); tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (in_ready === 1'b1) ok = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL send_byte_timeout: byte %h not accepted, in_ready=%b required 1", b, in_ready);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks += 8;
      if (busy !== 1'b0)          begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      if (in_ready !== 1'b0)      begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      if (WE !== 1'b0)            begin errors++; $display("FAIL rst_we: got %b want 0", WE); end
      if (A !== 32'h0)            begin errors++; $display("FAIL rst_a: got %h want 00000000", A); end
      if (WD !== 32'h0)           begin errors++; $display("FAIL rst_wd: got %h want 00000000", WD); end
      if (done !== 1'b0)          begin errors++; $display("FAIL rst_done: got %b want 0", done); end
      if (err !== 1'b0)           begin errors++; $display("FAIL rst_err: got %b want 0", err); end
      if (words_written !== 16'd0) begin errors++; $display("FAIL rst_words: got %0d want 0", words_written); end
   endtask

   task automatic test_basic_load();
      we_cnt = 0;
      pulse_start();
      checks += 2;
      if (busy !== 1'b1)     begin errors++; $display("FAIL basic_busy_len0: got %b want 1", busy); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_len0: got %b want 1", in_ready); end
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
      checks += 4;
      if (WE !== 1'b1)             begin errors++; $display("FAIL basic_we_latency: got %b want 1", WE); end
      if (A !== 32'h0)             begin errors++; $display("FAIL basic_a0: got %h want 00000000", A); end
      if (WD !== 32'h00A00513)     begin errors++; $display("FAIL basic_wd0: got %h want 00a00513", WD); end
      if (in_ready !== 1'b0)       begin errors++; $display("FAIL basic_ready_write: got %b want 0", in_ready); end
      tick();
      checks += 3;
      if (WE !== 1'b0)             begin errors++; $display("FAIL basic_we_one_cycle: got %b want 0", WE); end
      if (WD !== 32'h00A00513)     begin errors++; $display("FAIL basic_wd_hold: got %h want 00a00513", WD); end
      if (words_written !== 16'd1) begin errors++; $display("FAIL basic_words1: got %0d want 1", words_written); end
      send_byte(8'h93); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
      tick(); tick();
      checks += 9;
      if (we_cnt !== 2)              begin errors++; $display("FAIL basic_we_count: got %0d want 2", we_cnt); end
      if (we_a[1] !== 32'h4)         begin errors++; $display("FAIL basic_a1: got %h want 00000004", we_a[1]); end
      if (we_wd[1] !== 32'h00100593) begin errors++; $display("FAIL basic_wd1: got %h want 00100593", we_wd[1]); end
      if (we_cyc[1] - we_cyc[0] !== 5) begin errors++; $display("FAIL basic_throughput: got %0d cycles want 5", we_cyc[1] - we_cyc[0]); end
      if (done !== 1'b1)             begin errors++; $display("FAIL basic_done: got %b want 1", done); end
      if (err !== 1'b0)              begin errors++; $display("FAIL basic_err: got %b want 0", err); end
      if (words_written !== 16'd2)   begin errors++; $display("FAIL basic_words2: got %0d want 2", words_written); end
      if (busy !== 1'b0)             begin errors++; $display("FAIL basic_busy_done: got %b want 0", busy); end
      if (A !== 32'h4)               begin errors++; $display("FAIL basic_a_hold: got %h want 00000004", A); end
      // Bytes offered while not ready must be ignored.
      in_valid = 1'b1; in_data = 8'hFF;
      tick(); tick(); tick();
      in_valid = 1'b0;
      checks += 3;
      if (we_cnt !== 2)            begin errors++; $display("FAIL ignore_we: got %0d want 2", we_cnt); end
      if (done !== 1'b1)           begin errors++; $display("FAIL ignore_done: got %b want 1", done); end
      if (words_written !== 16'd2) begin errors++; $display("FAIL ignore_words: got %0d want 2", words_written); end
   endtask

   task automatic test_zero_length();
      we_cnt = 0;
      pulse_start();
      checks += 2;
      if (done !== 1'b0)           begin errors++; $display("FAIL zero_done_cleared: got %b want 0", done); end
      if (words_written !== 16'd0) begin errors++; $display("FAIL zero_words_cleared: got %0d want 0", words_written); end
      send_byte(8'h00); send_byte(8'h00);
      tick();
      checks += 4;
      if (done !== 1'b1)           begin errors++; $display("FAIL zero_done: got %b want 1", done); end
      if (we_cnt !== 0)            begin errors++; $display("FAIL zero_no_we: got %0d want 0", we_cnt); end
      if (words_written !== 16'd0) begin errors++; $display("FAIL zero_words: got %0d want 0", words_written); end
      if (busy !== 1'b0)           begin errors++; $display("FAIL zero_busy: got %b want 0", busy); end
   endtask

   task automatic test_length_bounds();
      we_cnt = 0;
      pulse_start();
      send_byte(8'h01); send_byte(8'h04);
      tick();
      checks += 5;
      if (err !== 1'b1)      begin errors++; $display("FAIL over_err: got %b want 1", err); end
      if (done !== 1'b0)     begin errors++; $display("FAIL over_done: got %b want 0", done); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL over_ready: got %b want 0", in_ready); end
      if (busy !== 1'b0)     begin errors++; $display("FAIL over_busy: got %b want 0", busy); end
      if (we_cnt !== 0)      begin errors++; $display("FAIL over_no_we: got %0d want 0", we_cnt); end
      pulse_start();
      checks += 1;
      if (err !== 1'b0)      begin errors++; $display("FAIL over_err_cleared: got %b want 0", err); end
      send_byte(8'h00); send_byte(8'h04);
      checks += 3;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL depth_ready: got %b want 1", in_ready); end
      if (busy !== 1'b1)     begin errors++; $display("FAIL depth_busy: got %b want 1", busy); end
      if (err !== 1'b0)      begin errors++; $display("FAIL depth_err: got %b want 0", err); end
      do_reset();
   endtask

   task automatic test_stall();
      we_cnt = 0;
      pulse_start();
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'hEF); in_data = 8'h55; tick();
      send_byte(8'hBE); in_data = 8'h66; tick(); tick(); tick();
      checks += 2;
      if (WE !== 1'b0)   begin errors++; $display("FAIL stall_we: got %b want 0", WE); end
      if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b want 1", busy); end
      send_byte(8'hAD); tick();
      send_byte(8'hDE); tick(); tick();
      checks += 5;
      if (we_cnt !== 1)              begin errors++; $display("FAIL stall_we_count: got %0d want 1", we_cnt); end
      if (we_wd[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_wd: got %h want deadbeef", we_wd[0]); end
      if (we_a[0] !== 32'h0)         begin errors++; $display("FAIL stall_a: got %h want 00000000", we_a[0]); end
      if (done !== 1'b1)             begin errors++; $display("FAIL stall_done: got %b want 1", done); end
      if (words_written !== 16'd1)   begin errors++; $display("FAIL stall_words: got %0d want 1", words_written); end
   endtask

   task automatic test_reset_mid();
      we_cnt = 0;
      pulse_start();
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22);
      rst = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 8'h33;
      tick();
      start = 1'b0; in_valid = 1'b0;
      checks += 8;
      if (busy !== 1'b0)           begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
      if (in_ready !== 1'b0)       begin errors++; $display("FAIL mid_ready: got %b want 0", in_ready); end
      if (WE !== 1'b0)             begin errors++; $display("FAIL mid_we: got %b want 0", WE); end
      if (A !== 32'h0)             begin errors++; $display("FAIL mid_a: got %h want 00000000", A); end
      if (WD !== 32'h0)            begin errors++; $display("FAIL mid_wd: got %h want 00000000", WD); end
      if (done !== 1'b0)           begin errors++; $display("FAIL mid_done: got %b want 0", done); end
      if (err !== 1'b0)            begin errors++; $display("FAIL mid_err: got %b want 0", err); end
      if (words_written !== 16'd0) begin errors++; $display("FAIL mid_words: got %0d want 0", words_written); end
      rst = 1'b1;
      tick(); tick(); tick();
      checks += 1;
      if (we_cnt !== 0) begin errors++; $display("FAIL mid_no_stale_we: got %0d want 0", we_cnt); end
      pulse_start();
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
      checks += 3;
      if (WE !== 1'b1)         begin errors++; $display("FAIL reload_we: got %b want 1", WE); end
      if (A !== 32'h0)         begin errors++; $display("FAIL reload_a: got %h want 00000000", A); end
      if (WD !== 32'h11223344) begin errors++; $display("FAIL reload_wd: got %h want 11223344", WD); end
      tick();
      checks += 1;
      if (done !== 1'b1) begin errors++; $display("FAIL reload_done: got %b want 1", done); end
   endtask

   task automatic test_start_ignored();
      we_cnt = 0;
      pulse_start();
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h02);
      pulse_start();
      checks += 2;
      if (in_ready !== 1'b1)       begin errors++; $display("FAIL busy_start_ready: got %b want 1", in_ready); end
      if (words_written !== 16'd0) begin errors++; $display("FAIL busy_start_words: got %0d want 0", words_written); end
      send_byte(8'h03); send_byte(8'h04);
      checks += 2;
      if (WE !== 1'b1)         begin errors++; $display("FAIL busy_start_we: got %b want 1", WE); end
      if (WD !== 32'h04030201) begin errors++; $display("FAIL busy_start_wd0: got %h want 04030201", WD); end
      send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
      tick();
      checks += 5;
      if (we_cnt !== 2)              begin errors++; $display("FAIL busy_start_count: got %0d want 2", we_cnt); end
      if (we_a[1] !== 32'h4)         begin errors++; $display("FAIL busy_start_a1: got %h want 00000004", we_a[1]); end
      if (we_wd[1] !== 32'h08070605) begin errors++; $display("FAIL busy_start_wd1: got %h want 08070605", we_wd[1]); end
      if (done !== 1'b1)             begin errors++; $display("FAIL busy_start_done: got %b want 1", done); end
      if (words_written !== 16'd2)   begin errors++; $display("FAIL busy_start_words2: got %0d want 2", words_written); end
      pulse_start();
      checks += 3;
      if (done !== 1'b0)     begin errors++; $display("FAIL restart_done: got %b want 0", done); end
      if (busy !== 1'b1)     begin errors++; $display("FAIL restart_busy: got %b want 1", busy); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL restart_ready: got %b want 1", in_ready); end
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      checks += 2;
      if (A !== 32'h0)         begin errors++; $display("FAIL restart_a: got %h want 00000000", A); end
      if (WD !== 32'hDDCCBBAA) begin errors++; $display("FAIL restart_wd: got %h want ddccbbaa", WD); end
      tick();
      checks += 1;
      if (done !== 1'b1) begin errors++; $display("FAIL restart_done_final: got %b want 1", done); end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      test_reset();
      test_basic_load();
      test_zero_length();
      test_length_bounds();
      test_stall();
      test_reset_mid();
      test_start_ignored();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
